// File: rtl/fir_stream_ctrl.sv
// rtl/fir_stream_ctrl.sv - fir issue sequencer with credit flow control and tail flush (optional stats: FIR_STREAM_CTRL_STATS_EN)
module fir_stream_ctrl #(
    parameter int DATA_W      = 16,
    parameter int TAPS        = 8,
    parameter int ISSUE_GAP   = 2,
    parameter int IN_DEPTH    = 8,
    parameter int OUT_DEPTH   = 8,
    parameter int FIR_LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    input  logic              flush_req,
    output logic              flush_busy,
    output logic              flush_done,
    output logic              fir_valid_in,
    output logic [DATA_W-1:0] fir_data_in,
    input  logic              fir_valid_out,
    input  logic [DATA_W-1:0] fir_data_out,
    output logic              err_unexpected
`ifdef FIR_STREAM_CTRL_STATS_EN
    ,
    output logic [31:0]       stat_issued,
    output logic [31:0]       stat_stall
`endif
);

    typedef enum logic [1:0] {RUN, FLUSH_IN, FLUSH_Z, FLUSH_WAIT} state_t;

    localparam int IAW = $clog2(IN_DEPTH);
    localparam int OAW = $clog2(OUT_DEPTH);
    localparam int GW  = $clog2(ISSUE_GAP + 1);
    localparam int ZW  = $clog2(TAPS + 1);
    localparam logic [IAW:0]   IN_LIM   = (IAW + 1)'(IN_DEPTH);
    localparam logic [OAW:0]   OUT_FULL = (OAW + 1)'(OUT_DEPTH);
    localparam logic [OAW+1:0] OUT_LIM  = (OAW + 2)'(OUT_DEPTH);
    localparam logic [GW-1:0]  GAP_C    = GW'(ISSUE_GAP);
    localparam logic [ZW-1:0]  TAPS_C   = ZW'(TAPS);

    logic [DATA_W-1:0] in_mem  [IN_DEPTH];
    logic [DATA_W-1:0] out_mem [OUT_DEPTH];

    state_t            state_q, state_d;
    logic [IAW-1:0]    in_wr_q, in_rd_q;
    logic [IAW:0]      in_cnt_q, in_cnt_d;
    logic [OAW-1:0]    out_wr_q, out_rd_q;
    logic [OAW:0]      out_cnt_q, out_cnt_d;
    logic [OAW:0]      inflight_q, inflight_d;
    logic [GW-1:0]     gap_q, gap_d;
    logic [ZW-1:0]     zcnt_q, zcnt_d;
    logic              s_ready_q, flush_busy_q, flush_done_q, flush_done_d;
    logic              fir_valid_q, err_q;
    logic [DATA_W-1:0] fir_data_q;

    logic in_push, in_pop, out_pop, ret_ok, src_avail, credit_ok, issue;

    // Issue decision, FIFO occupancy, in-flight credit and flush sequencing
    always_comb begin
        in_push   = s_valid && s_ready_q;
        out_pop   = (out_cnt_q != '0) && m_ready;
        ret_ok    = fir_valid_out && (inflight_q != '0);
        case (state_q)
            RUN, FLUSH_IN: src_avail = (in_cnt_q != '0);
            FLUSH_Z:       src_avail = (zcnt_q != '0);
            default:       src_avail = 1'b0;
        endcase
        credit_ok = ({1'b0, out_cnt_q} + {1'b0, inflight_q}) < OUT_LIM;
        issue     = src_avail && credit_ok && (gap_q >= GAP_C);
        in_pop    = issue && (state_q != FLUSH_Z);

        in_cnt_d = in_cnt_q;
        if (in_push && !in_pop)      in_cnt_d = in_cnt_q + 1'b1;
        else if (!in_push && in_pop) in_cnt_d = in_cnt_q - 1'b1;

        out_cnt_d = out_cnt_q;
        if (ret_ok && !out_pop)      out_cnt_d = out_cnt_q + 1'b1;
        else if (!ret_ok && out_pop) out_cnt_d = out_cnt_q - 1'b1;

        inflight_d = inflight_q;
        if (issue && !ret_ok)      inflight_d = inflight_q + 1'b1;
        else if (!issue && ret_ok) inflight_d = inflight_q - 1'b1;

        gap_d = gap_q;
        if (issue)              gap_d = GW'(1);
        else if (gap_q < GAP_C) gap_d = gap_q + 1'b1;

        state_d      = state_q;
        zcnt_d       = zcnt_q;
        flush_done_d = 1'b0;
        if (issue && state_q == FLUSH_Z) zcnt_d = zcnt_q - 1'b1;
        case (state_q)
            RUN:        if (flush_req) state_d = FLUSH_IN;
            FLUSH_IN:   if (in_cnt_q == '0) begin
                            state_d = FLUSH_Z;
                            zcnt_d  = TAPS_C;
                        end
            FLUSH_Z:    if (zcnt_q == '0) state_d = FLUSH_WAIT;
            FLUSH_WAIT: if (inflight_q == '0) begin
                            state_d      = RUN;
                            flush_done_d = 1'b1;
                        end
            default:    state_d = RUN;
        endcase
    end

    // Control state, pointers, counters and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= RUN;
            in_wr_q      <= '0;
            in_rd_q      <= '0;
            in_cnt_q     <= '0;
            out_wr_q     <= '0;
            out_rd_q     <= '0;
            out_cnt_q    <= '0;
            inflight_q   <= '0;
            gap_q        <= GAP_C;
            zcnt_q       <= '0;
            s_ready_q    <= 1'b0;
            flush_busy_q <= 1'b0;
            flush_done_q <= 1'b0;
            fir_valid_q  <= 1'b0;
            fir_data_q   <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            in_cnt_q     <= in_cnt_d;
            out_cnt_q    <= out_cnt_d;
            inflight_q   <= inflight_d;
            gap_q        <= gap_d;
            zcnt_q       <= zcnt_d;
            s_ready_q    <= (state_d == RUN) && (in_cnt_d < IN_LIM);
            flush_busy_q <= (state_d != RUN);
            flush_done_q <= flush_done_d;
            fir_valid_q  <= issue;
            if (in_push) in_wr_q  <= in_wr_q + 1'b1;
            if (in_pop)  in_rd_q  <= in_rd_q + 1'b1;
            if (ret_ok)  out_wr_q <= out_wr_q + 1'b1;
            if (out_pop) out_rd_q <= out_rd_q + 1'b1;
            if (issue)   fir_data_q <= (state_q == FLUSH_Z) ? '0 : in_mem[in_rd_q];
            if (fir_valid_out && inflight_q == '0) err_q <= 1'b1;
        end
    end

    // FIFO storage needs no reset; occupancy is tracked by the counters
    always_ff @(posedge clk) begin
        if (in_push) in_mem[in_wr_q]   <= s_data;
        if (ret_ok)  out_mem[out_wr_q] <= fir_data_out;
    end

    // Credit accounting must make an output FIFO overflow unreachable
    always @(posedge clk) begin
        if (!rst) begin
            assert (OUT_DEPTH >= FIR_LATENCY + 1);
            assert (!(ret_ok && !out_pop && out_cnt_q == OUT_FULL));
        end
    end

`ifdef FIR_STREAM_CTRL_STATS_EN
    logic [31:0] stat_issued_q, stat_stall_q;

    // Saturating issue and stall counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_issued_q <= '0;
            stat_stall_q  <= '0;
        end else begin
            if (issue && stat_issued_q != '1) stat_issued_q <= stat_issued_q + 1'b1;
            if (src_avail && !issue && stat_stall_q != '1) stat_stall_q <= stat_stall_q + 1'b1;
        end
    end

    assign stat_issued = stat_issued_q;
    assign stat_stall  = stat_stall_q;
`endif

    assign s_ready        = s_ready_q;
    assign m_valid        = (out_cnt_q != '0);
    assign m_data         = (out_cnt_q != '0) ? out_mem[out_rd_q] : '0;
    assign flush_busy     = flush_busy_q;
    assign flush_done     = flush_done_q;
    assign fir_valid_in   = fir_valid_q;
    assign fir_data_in    = fir_data_q;
    assign err_unexpected = err_q;

endmodule
